// File: rtl/tx_sym_pkg.sv
// Shared definitions for the Tx symbol scheduler.
// Contents:
//   K_COM, K_IDL  - control characters placed on the lane (K28.5 comma, idle)
//   state_e       - scheduler FSM state encoding (3-bit)
//   is_k_char     - flags a data byte that collides with a control character
package tx_sym_pkg;

  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_IDL = 8'h7C;

  typedef enum logic [2:0] {
    ST_OFF  = 3'd0,
    ST_SYNC = 3'd1,
    ST_IDLE = 3'd2,
    ST_DATA = 3'd3,
    ST_SKIP = 3'd4
  } state_e;

  function automatic logic is_k_char(input logic [7:0] b);
    return (b == K_COM) || (b == K_IDL);
  endfunction

endpackage

// File: rtl/tx_symbol_scheduler_rr_arbiter_2.sv
// Two-way round-robin arbiter with grant hold.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   req_i[1:0]  - request lines (bit n = requester n)
//   hold_i      - current grant was used for a non-final symbol; keep it
//   release_i   - current grant was used for the final symbol; drop it
//   gnt_o[1:0]  - one-hot grant (held grant while busy, else RR choice)
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       hold_i,
  input  logic       release_i,
  output logic [1:0] gnt_o
);

  logic [1:0] own_q, own_d;
  logic       ptr_q, ptr_d;
  logic [1:0] pick;

  // A held grant always wins, so a packet is never preempted. With both
  // requesting, ptr_q names the requester that has priority this round.
  always_comb begin
    pick = req_i;
    if (req_i == 2'b11) begin
      pick = ptr_q ? 2'b10 : 2'b01;
    end
    gnt_o = (own_q != 2'b00) ? own_q : pick;

    own_d = own_q;
    ptr_d = ptr_q;
    if (release_i) begin
      own_d = 2'b00;
      // Serving requester 0 hands priority to requester 1, and vice versa.
      ptr_d = gnt_o[0];
    end else if (hold_i) begin
      own_d = gnt_o;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      own_q <= 2'b00;
      ptr_q <= 1'b0;
    end else begin
      own_q <= own_d;
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/tx_symbol_scheduler.sv
// Symbol sequencer for the parallel-to-serial Tx lane.
// After enable it sends a COM burst, then fills idle time with IDL while
// round-robin arbitrating two packet requesters. A COM skip symbol is
// inserted at packet boundaries every SKIP_INTERVAL link symbol times.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   enable                      - link enable (level)
//   reqN_valid/data/last/ready  - requester N symbol handshake (ready is combinational)
//   sym_out, sym_valid          - registered symbol to serializer
//   link_up                     - registered, high while in IDLE/DATA/SKIP
//   data_err                    - registered pulse alongside a data byte equal to a K char
module tx_symbol_scheduler
  import tx_sym_pkg::*;
#(
  parameter int unsigned COM_BURST     = 4,
  parameter int unsigned SKIP_INTERVAL = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] sym_out,
  output logic       sym_valid,
  output logic       link_up,
  output logic       data_err
);

  localparam logic [3:0] BURST_LAST = 4'(COM_BURST - 1);
  localparam logic [7:0] SKIP_LAST  = 8'(SKIP_INTERVAL - 1);

  state_e     state_q, state_d;
  logic [3:0] burst_q, burst_d;
  logic [7:0] skip_cnt_q, skip_cnt_d;
  logic       skip_pend_q, skip_pend_d;
  logic [7:0] sym_q, sym_d;
  logic       sym_valid_q, sym_valid_d;
  logic       link_up_q, link_up_d;
  logic       data_err_q, data_err_d;

  logic [1:0] gnt;
  logic [1:0] take;
  logic       grant_ok;
  logic       acc;
  logic [7:0] acc_data;
  logic       acc_last;

  // A new grant in IDLE is blocked by a pending skip or a dropped enable,
  // which gives those events priority over arbitration at a boundary.
  assign grant_ok = !reset &&
                    ((state_q == ST_DATA) ||
                     (state_q == ST_IDLE && !skip_pend_q && enable));

  assign take       = gnt & {req1_valid, req0_valid} & {2{grant_ok}};
  assign req0_ready = take[0];
  assign req1_ready = take[1];
  assign acc        = |take;
  assign acc_data   = take[1] ? req1_data : req0_data;
  assign acc_last   = take[1] ? req1_last : req0_last;

  rr_arbiter_2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_i     ({req1_valid, req0_valid}),
    .hold_i    (acc & ~acc_last),
    .release_i (acc & acc_last),
    .gnt_o     (gnt)
  );

  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    skip_cnt_d  = skip_cnt_q;
    skip_pend_d = skip_pend_q;
    sym_d       = 8'h00;
    sym_valid_d = 1'b0;
    data_err_d  = 1'b0;
    link_up_d   = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_SKIP);

    case (state_q)
      ST_OFF: begin
        if (enable) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (!enable) begin
          state_d = ST_OFF;
          burst_d = 4'd0;
        end else begin
          sym_d       = K_COM;
          sym_valid_d = 1'b1;
          if (burst_q == BURST_LAST) begin
            burst_d = 4'd0;
            state_d = ST_IDLE;
          end else begin
            burst_d = burst_q + 4'd1;
          end
        end
      end
      ST_SKIP: begin
        sym_d       = K_COM;
        sym_valid_d = 1'b1;
        skip_pend_d = 1'b0;
        state_d     = ST_IDLE;
      end
      ST_IDLE, ST_DATA: begin
        sym_valid_d = 1'b1;
        sym_d       = K_IDL;
        if (acc) begin
          sym_d      = acc_data;
          data_err_d = is_k_char(acc_data);
          if (acc_last) begin
            if (skip_pend_q)  state_d = ST_SKIP;
            else if (!enable) state_d = ST_OFF;
            else              state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end else if (state_q == ST_IDLE) begin
          if (skip_pend_q)  state_d = ST_SKIP;
          else if (!enable) state_d = ST_OFF;
        end
      end
      default: state_d = ST_OFF;
    endcase

    // Reaching the interval while a skip is already pending just keeps the
    // single flag set; a new interval elapsing in the SKIP cycle re-arms it.
    if (link_up_d) begin
      if (skip_cnt_q == SKIP_LAST) begin
        skip_cnt_d  = 8'd0;
        skip_pend_d = 1'b1;
      end else begin
        skip_cnt_d = skip_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_OFF;
      burst_q     <= 4'd0;
      skip_cnt_q  <= 8'd0;
      skip_pend_q <= 1'b0;
      sym_q       <= 8'h00;
      sym_valid_q <= 1'b0;
      link_up_q   <= 1'b0;
      data_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      skip_cnt_q  <= skip_cnt_d;
      skip_pend_q <= skip_pend_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      link_up_q   <= link_up_d;
      data_err_q  <= data_err_d;
    end
  end

  assign sym_out   = sym_q;
  assign sym_valid = sym_valid_q;
  assign link_up   = link_up_q;
  assign data_err  = data_err_q;

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// Randomized self-checking bench for tx_symbol_scheduler.
// Requesters replay packet queues with random valid gaps; enable and reset
// are toggled at random. A link-level reference model predicts each cycle's
// ready lines and the symbol that must appear on the lane one edge later.
module tb_tx_symbol_scheduler;

  localparam int COM_BURST     = 4;
  localparam int SKIP_INTERVAL = 8;
  localparam int NUM_CYCLES    = 4000;

  localparam int P_OFF  = 0;
  localparam int P_SYNC = 1;
  localparam int P_IDLE = 2;
  localparam int P_DATA = 3;
  localparam int P_SKIP = 4;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic       req0_valid, req0_last, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req1_data;
  logic [7:0] sym_out;
  logic       sym_valid, link_up, data_err;

  always #5 clk = ~clk;

  tx_symbol_scheduler #(
    .COM_BURST     (COM_BURST),
    .SKIP_INTERVAL (SKIP_INTERVAL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .sym_out    (sym_out),
    .sym_valid  (sym_valid),
    .link_up    (link_up),
    .data_err   (data_err)
  );

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] q0Data[$];
  bit         q0Last[$];
  logic [7:0] q1Data[$];
  bit         q1Last[$];
  int         validPct;

  // Reference model state, in link terms rather than registers.
  int         mPhase;
  int         mOwner;
  int         mPtr;
  int         mBurst;
  int         mCount;
  bit         mPend;
  logic [7:0] expSym;
  logic       expValid, expLink, expErr;
  logic       expReady0, expReady1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  function automatic logic [7:0] pickByte();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 8'h7C;
    if (r == 1) return 8'hBC;
    return 8'($urandom);
  endfunction

  task automatic addPacket(input int who, input int len);
    for (int i = 0; i < len; i++) begin
      if (who == 0) begin
        q0Data.push_back(pickByte());
        q0Last.push_back(i == len - 1);
      end else begin
        q1Data.push_back(pickByte());
        q1Last.push_back(i == len - 1);
      end
    end
  endtask

  function automatic bit validOf(input int who);
    return (who == 0) ? req0_valid : req1_valid;
  endfunction

  task automatic applyStimulus(input int cyc);
    if (cyc < 3) begin
      reset  = 1'b1;
      enable = 1'b0;
    end else begin
      reset = (cyc > 300) && ($urandom_range(0, 399) == 0);
      if (cyc == 3) enable = 1'b1;
      else if (cyc > 200 && $urandom_range(0, 79) == 0) enable = ~enable;
    end

    // Directed opening: a 3-symbol packet, then two packets contending.
    if (cyc == 12) begin
      q0Data = '{8'h11, 8'h22, 8'h33};
      q0Last = '{1'b0, 1'b0, 1'b1};
    end
    if (cyc == 20) begin
      q0Data.push_back(8'h66); q0Last.push_back(1'b0);
      q0Data.push_back(8'h7C); q0Last.push_back(1'b1);
      q1Data.push_back(8'h44); q1Last.push_back(1'b0);
      q1Data.push_back(8'h55); q1Last.push_back(1'b1);
    end
    if (cyc == 40) addPacket(1, 20);

    if (cyc >= 60) begin
      if (q0Data.size() < 30 && $urandom_range(0, 7) == 0)
        addPacket(0, ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(1, 6));
      if (q1Data.size() < 30 && $urandom_range(0, 7) == 0)
        addPacket(1, ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(1, 6));
    end
    validPct = (cyc < 40) ? 100 : 75;

    req0_valid = (q0Data.size() > 0) && ($urandom_range(1, 100) <= validPct);
    req0_data  = (q0Data.size() > 0) ? q0Data[0] : 8'($urandom);
    req0_last  = (q0Last.size() > 0) ? q0Last[0] : 1'b0;
    req1_valid = (q1Data.size() > 0) && ($urandom_range(1, 100) <= validPct);
    req1_data  = (q1Data.size() > 0) ? q1Data[0] : 8'($urandom);
    req1_last  = (q1Last.size() > 0) ? q1Last[0] : 1'b0;
  endtask

  // One symbol time of the link: decides who is accepted now and what the
  // lane carries after the coming edge.
  task automatic modelStep();
    int         g;
    int         nextPhase;
    bit         linkNow;
    logic [7:0] d;
    bit         lst;

    expReady0 = 1'b0;
    expReady1 = 1'b0;
    if (reset) begin
      mPhase = P_OFF; mOwner = -1; mPtr = 0; mBurst = 0; mCount = 0; mPend = 0;
      expSym = 8'h00; expValid = 1'b0; expLink = 1'b0; expErr = 1'b0;
      return;
    end

    linkNow   = (mPhase == P_IDLE) || (mPhase == P_DATA) || (mPhase == P_SKIP);
    expSym    = 8'h00;
    expValid  = linkNow;
    expLink   = linkNow;
    expErr    = 1'b0;
    nextPhase = mPhase;

    g = -1;
    if (mPhase == P_DATA) begin
      if (validOf(mOwner)) g = mOwner;
    end else if (mPhase == P_IDLE && !mPend && enable) begin
      if (req0_valid && req1_valid) g = mPtr;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
    end

    case (mPhase)
      P_OFF: if (enable) nextPhase = P_SYNC;
      P_SYNC: begin
        if (!enable) begin
          nextPhase = P_OFF;
          mBurst    = 0;
        end else begin
          expSym   = 8'hBC;
          expValid = 1'b1;
          mBurst++;
          if (mBurst == COM_BURST) begin
            mBurst    = 0;
            nextPhase = P_IDLE;
          end
        end
      end
      P_SKIP: begin
        expSym    = 8'hBC;
        mPend     = 0;
        nextPhase = P_IDLE;
      end
      default: begin
        expSym = 8'h7C;
        if (g >= 0) begin
          if (g == 0) begin expReady0 = 1'b1; d = req0_data; lst = req0_last; end
          else        begin expReady1 = 1'b1; d = req1_data; lst = req1_last; end
          expSym = d;
          expErr = (d == 8'hBC) || (d == 8'h7C);
          if (lst) begin
            mOwner = -1;
            mPtr   = 1 - g;
            nextPhase = mPend ? P_SKIP : (!enable ? P_OFF : P_IDLE);
          end else begin
            mOwner    = g;
            nextPhase = P_DATA;
          end
        end else if (mPhase == P_IDLE) begin
          if (mPend)        nextPhase = P_SKIP;
          else if (!enable) nextPhase = P_OFF;
        end
      end
    endcase

    if (linkNow) begin
      if (mCount == SKIP_INTERVAL - 1) begin
        mCount = 0;
        mPend  = 1;
      end else begin
        mCount++;
      end
    end
    mPhase = nextPhase;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0;
    req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
    mPhase = P_OFF; mOwner = -1; mPtr = 0; mBurst = 0; mCount = 0; mPend = 0;
    expSym = 8'h00; expValid = 1'b0; expLink = 1'b0; expErr = 1'b0;
    expReady0 = 1'b0; expReady1 = 1'b0;

    for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
      @(posedge clk);
      #1;
      applyStimulus(cyc);
      @(negedge clk);
      checkOutput("sym_out",   sym_out,   expSym);
      checkOutput("sym_valid", sym_valid, expValid);
      checkOutput("link_up",   link_up,   expLink);
      checkOutput("data_err",  data_err,  expErr);
      modelStep();
      checkOutput("req0_ready", req0_ready, expReady0);
      checkOutput("req1_ready", req1_ready, expReady1);
      if (expReady0 && q0Data.size() > 0) begin
        void'(q0Data.pop_front());
        void'(q0Last.pop_front());
      end
      if (expReady1 && q1Data.size() > 0) begin
        void'(q1Data.pop_front());
        void'(q1Last.pop_front());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
